if_prefetch: RTL and testbench
==============================

IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter BUS_WIDTH, default 32: program-counter and ROM address width.
REQ-002 Parameter DATA_WIDTH, default 32: instruction width.
REQ-003 Parameter FIFO_DEPTH, default 4: prefetch queue entries; power of two, at least 2.
REQ-004 Parameter RESET_PC, default 0: first fetch address after reset.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 branch  input  1  redirect request from EX.
REQ-008 branch_addr  input  BUS_WIDTH  redirect target.
REQ-009 rom_req_valid  output  1  fetch request valid.
REQ-010 rom_req_ready  input  1  ROM accepts the request this cycle.
REQ-011 rom_address  output  BUS_WIDTH  fetch address; bits [1:0] always 0.
REQ-012 rom_rsp_valid  input  1  ROM returns rom_rdata this cycle; responses arrive in request order.
REQ-013 rom_rdata  input  DATA_WIDTH  returned instruction.
REQ-014 ins_valid  output  1  queue head is valid for ID.
REQ-015 ins_ready  input  1  ID consumes the head this cycle; driven low to stall ID.
REQ-016 instruction_o  output  DATA_WIDTH  head instruction.
REQ-017 pc_o  output  BUS_WIDTH  PC of head instruction.

Function
REQ-018 Fetch PC register: advances by 4 on each accepted request (rom_req_valid and rom_req_ready), wraps modulo 2^BUS_WIDTH.
REQ-019 rom_address equals fetch PC; a request is accepted in the cycle it is issued; the request's PC is pushed into an in-flight PC queue at acceptance.
REQ-020 rom_req_valid is high when (queue occupancy + in-flight count) < FIFO_DEPTH and branch is low; otherwise low.
REQ-021 A response not being discarded pushes {in-flight head PC, rom_rdata} into the queue in the same cycle; latency from response to ins_valid is one cycle.
REQ-022 ins_valid is high whenever queue occupancy is nonzero; instruction_o and pc_o reflect the head entry and are held stable while ins_valid is high and ins_ready is low.
REQ-023 Pop occurs when ins_valid and ins_ready are both high; simultaneous push and pop leave occupancy unchanged.
REQ-024 Branch cycle: queue emptied, pop ignored, no request issued, fetch PC loaded with {branch_addr[BUS_WIDTH-1:2], 2'b00}.
REQ-025 Branch cycle: discard counter loaded with in-flight count minus any response arriving that same cycle; that response is dropped.
REQ-026 While the discard counter is nonzero, each rom_rsp_valid decrements it and the response is dropped, not enqueued.
REQ-027 A branch asserted while the discard counter is nonzero adds that cycle's in-flight count to the remaining discard count.
REQ-028 Occupancy and in-flight count never exceed FIFO_DEPTH; rom_rsp_valid with zero in-flight count is ignored.
REQ-029 Throughput: with a zero-wait ROM and ins_ready held high, one instruction per cycle after the initial fill.

Reset
REQ-030 On rst_n low, asynchronously: fetch PC = RESET_PC, queue empty, in-flight count = 0, discard counter = 0.
REQ-031 During reset: rom_req_valid = 0, ins_valid = 0, instruction_o = 0, pc_o = 0.
REQ-032 Reset asserted mid-fetch abandons all in-flight requests; ROM responses in the first cycle after release are ignored because in-flight count is 0.

Structure
REQ-033 BUS_WIDTH, DATA_WIDTH and the NOP encoding (32'h00000013) are defined in the shared include file.
REQ-034 One sub-module, ins_fifo: synchronous FIFO of {PC, instruction}, parameter FIFO_DEPTH, with push, pop, flush, full, empty and count.
REQ-035 The in-flight PC queue and the discard counter are kept in if_prefetch.

Verification
REQ-036 Reset release, zero-wait ROM, ins_ready = 1 -> pc_o sequence 0x0, 0x4, 0x8, one per cycle from the second cycle after release.
REQ-037 ins_ready = 0 for 10 cycles -> occupancy reaches 4, rom_req_valid falls low, pc_o stays 0x0, no entry is lost when ins_ready returns to 1.
REQ-038 branch with branch_addr = 0x103 while 2 requests are in flight -> both responses dropped, next rom_address = 0x100, next pc_o = 0x100.
REQ-039 branch in the same cycle as rom_rsp_valid and pop -> response dropped, queue empty next cycle, ins_valid = 0.
REQ-040 RESET_PC = 0xFFFFFFF8, 4 accepted fetches -> rom_address sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
REQ-041 rst_n pulsed low with 3 requests outstanding -> outputs clear immediately, fetch resumes at RESET_PC, stale responses are ignored.

Source files
------------

// File: rtl/if_prefetch_pkg.sv
// Shared definitions for the instruction-fetch prefetch unit.
// Provides default widths, the NOP encoding and the response-handling enum.
package if_prefetch_pkg;

  localparam int DEF_BUS_WIDTH  = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FIFO_DEPTH = 4;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // What happens to a ROM response in the current cycle
  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_ENQUEUE,
    RSP_DROP
  } rsp_action_e;

endpackage

// File: rtl/if_prefetch_if.sv
// Bundle of the branch, ROM request/response and ID-side handshake signals.
// The prefetch unit connects as master, the surrounding pipeline/ROM as slave.
interface if_prefetch_if import if_prefetch_pkg::*; #(
  parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                  branch;
  logic [BUS_WIDTH-1:0]  branch_addr;
  logic                  rom_req_valid;
  logic                  rom_req_ready;
  logic [BUS_WIDTH-1:0]  rom_address;
  logic                  rom_rsp_valid;
  logic [DATA_WIDTH-1:0] rom_rdata;
  logic                  ins_valid;
  logic                  ins_ready;
  logic [DATA_WIDTH-1:0] instruction_o;
  logic [BUS_WIDTH-1:0]  pc_o;

  modport master (
    input  branch, branch_addr, rom_req_ready, rom_rsp_valid, rom_rdata, ins_ready,
    output rom_req_valid, rom_address, ins_valid, instruction_o, pc_o
  );

  modport slave (
    output branch, branch_addr, rom_req_ready, rom_rsp_valid, rom_rdata, ins_ready,
    input  rom_req_valid, rom_address, ins_valid, instruction_o, pc_o
  );

endinterface

// File: rtl/if_prefetch_ins_fifo.sv
// Synchronous queue of {PC, instruction} pairs feeding the decode stage.
// Flush wins over push and pop in the same cycle.
module ins_fifo import if_prefetch_pkg::*; #(
  parameter int PC_WIDTH   = DEF_BUS_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int PTR_W = $clog2(FIFO_DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic                  i_flush,
  input  logic [PC_WIDTH-1:0]   i_pushPc,
  input  logic [DATA_WIDTH-1:0] i_pushData,
  output logic [PC_WIDTH-1:0]   o_headPc,
  output logic [DATA_WIDTH-1:0] o_headData,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [CNT_W-1:0]      o_count
);

  logic [PC_WIDTH-1:0]   r_pcMem   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_dataMem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_rdPtr;
  logic [PTR_W-1:0]      r_wrPtr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_doPush;
  logic                  w_doPop;

  assign o_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_headPc   = r_pcMem[r_rdPtr];
  assign o_headData = r_dataMem[r_rdPtr];

  // A full queue still accepts a push when the head leaves in the same cycle
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);

  always_ff @(posedge clk) begin
    if (w_doPush && !i_flush) begin
      r_pcMem[r_wrPtr]   <= i_pushPc;
      r_dataMem[r_wrPtr] <= i_pushData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      r_count <= r_count + CNT_W'(w_doPush) - CNT_W'(w_doPop);
    end
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch unit: issues sequential ROM fetches, tracks in-flight PCs,
// discards responses made stale by a branch and queues instructions for ID.
module if_prefetch import if_prefetch_pkg::*; #(
  parameter int                  BUS_WIDTH  = DEF_BUS_WIDTH,
  parameter int                  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                  FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter logic [BUS_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  if_prefetch_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Wide enough to absorb many back-to-back redirects before the ROM drains
  localparam int DISC_W = CNT_W + 8;
  localparam logic [BUS_WIDTH-1:0] ALIGN_MASK = ~BUS_WIDTH'(3);

  logic [BUS_WIDTH-1:0] r_fetchPc;
  logic [CNT_W-1:0]     r_inFlight;
  logic [BUS_WIDTH-1:0] r_pcq [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_pcqWr;
  logic [PTR_W-1:0]     r_pcqRd;
  logic [DISC_W-1:0]    r_discardCnt;

  logic [CNT_W-1:0]      w_fifoCount;
  logic                  w_fifoFull;
  logic                  w_fifoEmpty;
  logic [BUS_WIDTH-1:0]  w_headPc;
  logic [DATA_WIDTH-1:0] w_headData;
  logic [CNT_W:0]        w_occSum;
  logic                  w_reqValid;
  logic                  w_reqAccept;
  logic                  w_pop;
  logic [BUS_WIDTH-1:0]  w_branchTarget;
  rsp_action_e           w_rspAction;

  assign w_occSum       = {1'b0, w_fifoCount} + {1'b0, r_inFlight};
  assign w_reqValid     = rst_n && !bus.branch && (w_occSum < (CNT_W + 1)'(FIFO_DEPTH));
  assign w_reqAccept    = w_reqValid && bus.rom_req_ready;
  assign w_pop          = bus.ins_valid && bus.ins_ready && !bus.branch;
  assign w_branchTarget = bus.branch_addr & ALIGN_MASK;

  assign bus.rom_req_valid = w_reqValid;
  assign bus.rom_address   = r_fetchPc;
  assign bus.ins_valid     = !w_fifoEmpty;
  assign bus.instruction_o = bus.ins_valid ? w_headData : '0;
  assign bus.pc_o          = bus.ins_valid ? w_headPc : '0;

  // Older stale responses are always ahead of tracked ones, so discards go first
  always_comb begin
    w_rspAction = RSP_NONE;
    if (bus.rom_rsp_valid) begin
      if (r_discardCnt != '0) begin
        w_rspAction = RSP_DROP;
      end else if (r_inFlight != '0) begin
        w_rspAction = bus.branch ? RSP_DROP : RSP_ENQUEUE;
      end
    end
  end

  ins_fifo #(
    .PC_WIDTH   (BUS_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_insFifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_rspAction == RSP_ENQUEUE),
    .i_pop      (w_pop),
    .i_flush    (bus.branch),
    .i_pushPc   (r_pcq[r_pcqRd]),
    .i_pushData (bus.rom_rdata),
    .o_headPc   (w_headPc),
    .o_headData (w_headData),
    .o_full     (w_fifoFull),
    .o_empty    (w_fifoEmpty),
    .o_count    (w_fifoCount)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetchPc <= RESET_PC & ALIGN_MASK;
    end else if (bus.branch) begin
      r_fetchPc <= w_branchTarget;
    end else if (w_reqAccept) begin
      r_fetchPc <= r_fetchPc + BUS_WIDTH'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (w_reqAccept) r_pcq[r_pcqWr] <= r_fetchPc;
  end

  // A branch hands every outstanding request over to the discard counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inFlight <= '0;
      r_pcqWr    <= '0;
      r_pcqRd    <= '0;
    end else if (bus.branch) begin
      r_inFlight <= '0;
      r_pcqWr    <= '0;
      r_pcqRd    <= '0;
    end else begin
      if (w_reqAccept)                 r_pcqWr <= r_pcqWr + 1'b1;
      if (w_rspAction == RSP_ENQUEUE)  r_pcqRd <= r_pcqRd + 1'b1;
      r_inFlight <= r_inFlight + CNT_W'(w_reqAccept) - CNT_W'(w_rspAction == RSP_ENQUEUE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_discardCnt <= '0;
    end else if (bus.branch) begin
      r_discardCnt <= r_discardCnt + DISC_W'(r_inFlight) - DISC_W'(w_rspAction != RSP_NONE);
    end else if (w_rspAction == RSP_DROP) begin
      r_discardCnt <= r_discardCnt - DISC_W'(1);
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: streaming, stall, branch discard, wrap and reset.
// A queue-based ROM model answers accepted requests in order.
module tb_if_prefetch;

  logic        clk;
  logic        rst_n;
  logic        romHold;
  logic        romFlush;
  logic        staleInject;
  logic [31:0] romQ [$];
  int          checkCount = 0;
  int          errorCount = 0;

  if_prefetch_if #(.BUS_WIDTH(32), .DATA_WIDTH(32)) bus ();
  if_prefetch_if #(.BUS_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

  if_prefetch #(
    .BUS_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(4), .RESET_PC(32'h0000_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  if_prefetch #(
    .BUS_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(4), .RESET_PC(32'hFFFF_FFF8)
  ) dutWrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] romWord(input logic [31:0] addr);
    return addr ^ 32'hA500_0013;
  endfunction

  // ROM model: requests accepted at an edge are answered in the following cycle
  always @(posedge clk) begin
    if (bus.rom_req_valid && bus.rom_req_ready) romQ.push_back(bus.rom_address);
    if (romFlush) romQ.delete();
    if (staleInject) begin
      bus.rom_rsp_valid <= 1'b1;
      bus.rom_rdata     <= 32'hDEAD_BEEF;
    end else if (!romHold && romQ.size() > 0) begin
      bus.rom_rsp_valid <= 1'b1;
      bus.rom_rdata     <= romWord(romQ.pop_front());
    end else begin
      bus.rom_rsp_valid <= 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic br, input logic [31:0] brAddr,
                               input logic insReady, input logic romReady);
    bus.branch        = br;
    bus.branch_addr   = brAddr;
    bus.ins_ready     = insReady;
    bus.rom_req_ready = romReady;
  endtask

  task automatic doReset(input logic insReady);
    @(negedge clk);
    rst_n       = 1'b0;
    romFlush    = 1'b1;
    staleInject = 1'b0;
    applyStimulus(1'b0, 32'h0, insReady, 1'b1);
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    romFlush = 1'b0;
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    romHold     = 1'b0;
    romFlush    = 1'b1;
    staleInject = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    bus2.branch        = 1'b0;
    bus2.branch_addr   = 32'h0;
    bus2.rom_req_ready = 1'b1;
    bus2.rom_rsp_valid = 1'b0;
    bus2.rom_rdata     = 32'h0;
    bus2.ins_ready     = 1'b0;

    // Reset values and streaming start with a zero-wait ROM
    repeat (3) @(negedge clk);
    checkOutput("rstReqValid", 32'(bus.rom_req_valid), 32'd0);
    checkOutput("rstInsValid", 32'(bus.ins_valid), 32'd0);
    checkOutput("rstInsn", bus.instruction_o, 32'h0);
    checkOutput("rstPc", bus.pc_o, 32'h0);
    rst_n    = 1'b1;
    romFlush = 1'b0;
    #1;
    checkOutput("n0ReqValid", 32'(bus.rom_req_valid), 32'd1);
    checkOutput("n0Addr", bus.rom_address, 32'h0);
    checkOutput("n0InsValid", 32'(bus.ins_valid), 32'd0);
    checkOutput("wrapAddr", bus2.rom_address, 32'hFFFF_FFF8);
    @(negedge clk);
    checkOutput("n1InsValid", 32'(bus.ins_valid), 32'd0);
    checkOutput("wrapAddr", bus2.rom_address, 32'hFFFF_FFFC);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      checkOutput("streamValid", 32'(bus.ins_valid), 32'd1);
      checkOutput("streamPc", bus.pc_o, 32'(4 * (k - 2)));
      checkOutput("streamInsn", bus.instruction_o, romWord(32'(4 * (k - 2))));
      if (k < 4) checkOutput("wrapAddr", bus2.rom_address, 32'(4 * (k - 2)));
      else       checkOutput("wrapReqValid", 32'(bus2.rom_req_valid), 32'd0);
    end

    // ID stalled for ten cycles from reset, then drains without loss
    romHold = 1'b0;
    doReset(1'b0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c >= 2) checkOutput("stallPc", bus.pc_o, 32'h0);
    end
    checkOutput("stallReqValid", 32'(bus.rom_req_valid), 32'd0);
    checkOutput("stallValid", 32'(bus.ins_valid), 32'd1);
    checkOutput("stallInsn", bus.instruction_o, romWord(32'h0));
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checkOutput("drainPc", bus.pc_o, 32'(4 * k));
      checkOutput("drainInsn", bus.instruction_o, romWord(32'(4 * k)));
    end

    // Branch to 0x103 with two requests outstanding in the ROM
    romHold = 1'b1;
    doReset(1'b1);
    repeat (2) @(negedge clk);
    checkOutput("preBranchAddr", bus.rom_address, 32'h8);
    applyStimulus(1'b1, 32'h0000_0103, 1'b1, 1'b1);
    #1;
    checkOutput("branchReqValid", 32'(bus.rom_req_valid), 32'd0);
    @(negedge clk);
    checkOutput("branchTarget", bus.rom_address, 32'h100);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    romHold = 1'b0;
    #1;
    checkOutput("postBranchReqValid", 32'(bus.rom_req_valid), 32'd1);
    for (int c = 4; c <= 6; c++) begin
      @(negedge clk);
      checkOutput("discardValid", 32'(bus.ins_valid), 32'd0);
    end
    @(negedge clk);
    checkOutput("branchPc", bus.pc_o, 32'h100);
    checkOutput("branchInsn", bus.instruction_o, romWord(32'h100));
    @(negedge clk);
    checkOutput("branchPc2", bus.pc_o, 32'h104);
    checkOutput("branchInsn2", bus.instruction_o, romWord(32'h104));

    // Branch coinciding with a response and a pop
    checkOutput("coincideRsp", 32'(bus.rom_rsp_valid), 32'd1);
    applyStimulus(1'b1, 32'h0000_0200, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("flushValid", 32'(bus.ins_valid), 32'd0);
    checkOutput("flushPc", bus.pc_o, 32'h0);
    checkOutput("redirAddr", bus.rom_address, 32'h200);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("redirDiscard", 32'(bus.ins_valid), 32'd0);
    @(negedge clk);
    checkOutput("redirPc", bus.pc_o, 32'h200);
    checkOutput("redirInsn", bus.instruction_o, romWord(32'h200));

    // Reset pulse with three requests outstanding and a stale response after release
    romHold = 1'b0;
    doReset(1'b0);
    @(negedge clk);
    romHold = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("preRstValid", 32'(bus.ins_valid), 32'd1);
    checkOutput("preRstReqValid", 32'(bus.rom_req_valid), 32'd0);
    checkOutput("preRstAddr", bus.rom_address, 32'h10);
    rst_n    = 1'b0;
    romFlush = 1'b1;
    #1;
    checkOutput("midRstInsValid", 32'(bus.ins_valid), 32'd0);
    checkOutput("midRstReqValid", 32'(bus.rom_req_valid), 32'd0);
    checkOutput("midRstInsn", bus.instruction_o, 32'h0);
    checkOutput("midRstPc", bus.pc_o, 32'h0);
    @(negedge clk);
    romFlush    = 1'b0;
    staleInject = 1'b1;
    @(negedge clk);
    rst_n       = 1'b1;
    staleInject = 1'b0;
    romHold     = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    #1;
    checkOutput("resumeAddr", bus.rom_address, 32'h0);
    checkOutput("resumeReqValid", 32'(bus.rom_req_valid), 32'd1);
    @(negedge clk);
    checkOutput("staleIgnored", 32'(bus.ins_valid), 32'd0);
    @(negedge clk);
    checkOutput("resumePc", bus.pc_o, 32'h0);
    checkOutput("resumeInsn", bus.instruction_o, romWord(32'h0));

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
